pipe_reg: RTL and testbench

Parametrised elastic pipeline register: a chain of `STAGES` registered stages, each `WIDTH` bits wide with its own valid bit, moving data under a valid/ready handshake.
- Successor to the plain enable flop; supports backpressure, bubble collapsing, synchronous flush, a programmable reset value and an occupancy count.
- Sits between multicycle datapath units, e.g. fetch → decode and memory → writeback, where a stalled consumer must hold the producer without losing data.

---
 rtl/pipe_reg.sv | 101 ++++++++++
 tb/tb_pipe_reg.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg.sv
// pipe_reg: elastic pipeline register built from STAGES valid/data stages.
// Backpressure propagates through a combinational ready chain, so a valid
// word always advances into an empty downstream stage even while the output
// is stalled. A synchronous flush drops every word in flight. An asynchronous
// reset loads RESET_VAL into all data registers. The count output is a
// register that tracks how many stages currently hold valid data.
module pipe_reg #(
    parameter int               WIDTH     = 32,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH-1:0]                 out_data,
    output logic [$clog2(STAGES+1)-1:0]      count
);

    localparam int CW = $clog2(STAGES + 1);

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [WIDTH-1:0]  d_q [STAGES];
    logic [WIDTH-1:0]  d_d [STAGES];
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;

    // Upstream view of each stage: stage 0 is fed by the producer,
    // stage k by stage k-1.
    logic [STAGES-1:0] vin;
    logic [WIDTH-1:0]  din [STAGES];

    // r[k]: stage k may load at the next edge (empty, or its content moves on).
    logic [STAGES:0]   r;

    // Ready chain from the consumer back toward the producer.
    always_comb begin
        r[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            r[k] = ~v_q[k] | r[k+1];
        end
    end

    // Route producer and previous-stage contents to each stage input.
    always_comb begin
        vin[0] = in_valid;
        din[0] = in_data;
        for (int k = 1; k < STAGES; k++) begin
            vin[k] = v_q[k-1];
            din[k] = d_q[k-1];
        end
    end

    // Next-state of every stage plus the occupancy that results from it.
    // Data only loads behind a valid upstream word, so bubbles and flushes
    // leave the data registers untouched.
    always_comb begin
        v_d     = v_q;
        count_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            d_d[k] = d_q[k];
            if (flush) begin
                v_d[k] = 1'b0;
            end else if (r[k]) begin
                v_d[k] = vin[k];
                if (vin[k]) begin
                    d_d[k] = din[k];
                end
            end
            count_d = count_d + CW'(v_d[k]);
        end
    end

    // State registers; reset empties the pipe and preloads RESET_VAL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q     <= '0;
            count_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                d_q[k] <= RESET_VAL;
            end
        end else begin
            v_q     <= v_d;
            count_q <= count_d;
            for (int k = 0; k < STAGES; k++) begin
                d_q[k] <= d_d[k];
            end
        end
    end

    assign in_ready  = r[0] & ~flush;
    assign out_valid = v_q[STAGES-1];
    assign out_data  = d_q[STAGES-1];
    assign count     = count_q;

endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: directed vector table for backpressure, bubble collapse and
// flush, asynchronous reset checks, then randomized traffic compared against
// a word-position model of the pipeline.
module tb_pipe_reg;

    localparam int               W  = 32;
    localparam int               S  = 3;
    localparam logic [W-1:0]     RV = 32'hDEADBEEF;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   count;

    pipe_reg #(.WIDTH(W), .STAGES(S), .RESET_VAL(RV)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Model: words in flight in FIFO order, each with its stage position.
    // Every cycle each word moves one stage forward unless the word ahead
    // (after its own move) blocks it; the head leaves when consumed.
    logic [W-1:0] mq_d [$];
    int           mq_p [$];
    logic [W-1:0] m_last;   // last word to reach the output stage

    task automatic model_reset();
        mq_d.delete();
        mq_p.delete();
        m_last = RV;
    endtask

    function automatic logic model_ready(input logic ordy, input logic fl);
        int lim;
        int np;
        int start;
        if (fl) return 1'b0;
        lim   = S;
        start = 0;
        if (mq_d.size() > 0 && mq_p[0] == S - 1 && ordy) start = 1;
        for (int i = start; i < mq_p.size(); i++) begin
            np  = (mq_p[i] + 1 < lim - 1) ? mq_p[i] + 1 : lim - 1;
            lim = np;
        end
        return lim > 0;
    endfunction

    task automatic model_edge(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
        int lim;
        int np;
        if (fl) begin
            mq_d.delete();
            mq_p.delete();
            return;
        end
        if (mq_d.size() > 0 && mq_p[0] == S - 1 && ordy) begin
            void'(mq_d.pop_front());
            void'(mq_p.pop_front());
        end
        lim = S;
        for (int i = 0; i < mq_p.size(); i++) begin
            np      = (mq_p[i] + 1 < lim - 1) ? mq_p[i] + 1 : lim - 1;
            mq_p[i] = np;
            if (np == S - 1) m_last = mq_d[i];
            lim = np;
        end
        if (iv && lim > 0) begin
            mq_d.push_back(id);
            mq_p.push_back(0);
            if (S == 1) m_last = id;
        end
    endtask

    logic obs_ready;
    logic exp_ready;

    // One cycle: apply inputs just after an edge, sample in_ready before the
    // next edge, advance the model at the edge, leave #1 after it.
    task automatic drive(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
        obs_ready = in_ready;
        exp_ready = model_ready(ordy, fl);
        @(posedge clk);
        model_edge(iv, id, ordy, fl);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_in_ready"},  W'(obs_ready), W'(exp_ready));
        check({tag, "_out_valid"}, W'(out_valid), W'(mq_d.size() > 0 && mq_p[0] == S - 1));
        check({tag, "_out_data"},  out_data, m_last);
        check({tag, "_count"},     W'(count), W'(mq_d.size()));
    endtask

    typedef struct {
        logic         iv;
        logic [W-1:0] id;
        logic         ordy;
        logic         fl;
        logic         e_rdy;
        logic         e_ov;
        logic [W-1:0] e_od;
        logic [1:0]   e_cnt;
    } vec_t;

    localparam logic [W-1:0] A = 32'hA000_0001;
    localparam logic [W-1:0] B = 32'hB000_0002;
    localparam logic [W-1:0] C = 32'hC000_0003;
    localparam logic [W-1:0] D = 32'hD000_0004;
    localparam logic [W-1:0] E = 32'hE000_0005;
    localparam logic [W-1:0] F = 32'hF000_0006;
    localparam logic [W-1:0] G = 32'h1000_0007;
    localparam logic [W-1:0] H = 32'h2000_0008;

    vec_t tab [18];
    int   first_out;

    initial begin
        // Backpressure: A,B,C fill, D waits, then drains while D enters.
        tab[0]  = '{1'b1, A,  1'b0, 1'b0, 1'b1, 1'b0, RV, 2'd1};
        tab[1]  = '{1'b1, B,  1'b0, 1'b0, 1'b1, 1'b0, RV, 2'd2};
        tab[2]  = '{1'b1, C,  1'b0, 1'b0, 1'b1, 1'b1, A,  2'd3};
        tab[3]  = '{1'b1, D,  1'b0, 1'b0, 1'b0, 1'b1, A,  2'd3};
        tab[4]  = '{1'b1, D,  1'b1, 1'b0, 1'b1, 1'b1, B,  2'd3};
        tab[5]  = '{1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1, C,  2'd2};
        tab[6]  = '{1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1, D,  2'd1};
        tab[7]  = '{1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, D,  2'd0};
        // Bubble collapse under a stalled output.
        tab[8]  = '{1'b1, E,  1'b0, 1'b0, 1'b1, 1'b0, D,  2'd1};
        tab[9]  = '{1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, D,  2'd1};
        tab[10] = '{1'b1, F,  1'b0, 1'b0, 1'b1, 1'b1, E,  2'd2};
        tab[11] = '{1'b1, G,  1'b0, 1'b0, 1'b1, 1'b1, E,  2'd3};
        // Flush at count 2 with a word offered; it enters the cycle after.
        tab[12] = '{1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1, F,  2'd2};
        tab[13] = '{1'b1, H,  1'b0, 1'b1, 1'b0, 1'b0, F,  2'd0};
        tab[14] = '{1'b1, H,  1'b0, 1'b0, 1'b1, 1'b0, F,  2'd1};
        tab[15] = '{1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, F,  2'd1};
        tab[16] = '{1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1, H,  2'd1};
        tab[17] = '{1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, H,  2'd0};

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #2;
        // Reset state before any clock edge.
        check("rst_out_valid", W'(out_valid), W'(1'b0));
        check("rst_out_data",  out_data, RV);
        check("rst_count",     W'(count), W'(0));
        check("rst_in_ready",  W'(in_ready), W'(1'b1));
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        for (int i = 0; i < 18; i++) begin
            drive(tab[i].iv, tab[i].id, tab[i].ordy, tab[i].fl);
            check($sformatf("vec%0d_in_ready", i),  W'(obs_ready), W'(tab[i].e_rdy));
            check($sformatf("vec%0d_out_valid", i), W'(out_valid), W'(tab[i].e_ov));
            check($sformatf("vec%0d_out_data", i),  out_data, tab[i].e_od);
            check($sformatf("vec%0d_count", i),     W'(count), W'(tab[i].e_cnt));
        end

        // Asynchronous reset between edges with two words in flight.
        drive(1'b1, 32'h5555_0001, 1'b0, 1'b0);
        drive(1'b1, 32'h5555_0002, 1'b0, 1'b0);
        check_model("pre_areset");
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("areset_out_valid", W'(out_valid), W'(1'b0));
        check("areset_count",     W'(count), W'(0));
        check("areset_out_data",  out_data, RV);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Streaming 1,2,3,... with the consumer always ready.
        first_out = -1;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, W'(i + 1), 1'b1, 1'b0);
            check_model($sformatf("stream%0d", i));
            if (out_valid && first_out < 0) first_out = i;
        end
        check("stream_latency", W'(first_out), W'(S - 1));
        check("stream_full_count", W'(count), W'(S));

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom % 4) != 0, $urandom, ($urandom % 10) < 6, ($urandom % 40) == 0);
            check_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
